res_packer: RTL

- Reader for the distance-transform result memory. After the DT core finishes, it reads the 8-bit result map back through the result memory's read port.
- Each pixel is compared against a programmable threshold, and 16 pixels are packed into one 16-bit binary word in the same layout as the source image memory: pixel 16k+0 at bit 15 through pixel 16k+15 at bit 0.
- Packed words are streamed out over a valid/ready handshake. The block also counts pixels whose distance is at or above the threshold, for the downstream checker.

---
 rtl/res_packer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/res_packer.sv
// Result-map reader: thresholds 8-bit DT distances and packs 16 pixels per word
// (pixel 16k+0 in bit 15) onto a valid/ready stream, counting foreground pixels.
module res_packer #(
   parameter int N_WORDS = 1024,
   parameter int AW      = 14,
   parameter int WAW     = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [7:0]     thr,
   output logic           res_rd,
   output logic [AW-1:0]  res_addr,
   input  logic [7:0]     res_di,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [WAW-1:0] out_addr,
   output logic [15:0]    out_data,
   output logic [AW:0]    fg_count,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {IDLE, READ, LAST, OUT, DONE} state_t;

   localparam logic [WAW-1:0] LAST_WORD = WAW'(N_WORDS - 1);

   state_t         state_q, state_d;
   logic [3:0]     pix_q, pix_d;
   logic [WAW-1:0] word_q, word_d;
   logic [15:0]    shift_q, shift_d;
   logic [AW:0]    fg_q, fg_d;
   logic [7:0]     thr_q, thr_d;
   logic           rd_q, rd_d;
   logic           res_rd_q, res_rd_d;
   logic [AW-1:0]  res_addr_q, res_addr_d;
   logic           out_valid_q, out_valid_d;
   logic [WAW-1:0] out_addr_q, out_addr_d;
   logic [15:0]    out_data_q, out_data_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           pix_bit;

   assign pix_bit = (res_di >= thr_q);

   // NOTE: every _d starts from a default so no path through this block infers a latch.
   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      word_d      = word_q;
      shift_d     = shift_q;
      fg_d        = fg_q;
      thr_d       = thr_q;
      rd_d        = res_rd_q;
      res_rd_d    = 1'b0;
      res_addr_d  = '0;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      done_d      = done_q;

      // res_di belongs to the read issued one cycle earlier
      if (rd_q) begin
         shift_d = {shift_q[14:0], pix_bit};
         if (pix_bit) begin
            fg_d = fg_q + (AW+1)'(1);
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = READ;
               thr_d      = thr;
               word_d     = '0;
               pix_d      = '0;
               fg_d       = '0;
               done_d     = 1'b0;
               busy_d     = 1'b1;
               res_rd_d   = 1'b1;
               res_addr_d = '0;
            end
         end
         READ: begin
            if (pix_q == 4'd15) begin
               state_d = LAST;
            end else begin
               pix_d      = pix_q + 4'd1;
               res_rd_d   = 1'b1;
               res_addr_d = AW'({word_q, pix_q + 4'd1});
            end
         end
         LAST: begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_addr_d  = word_q;
            out_data_d  = shift_d;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_addr_d  = '0;
               out_data_d  = '0;
               if (word_q == LAST_WORD) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d    = READ;
                  word_d     = word_q + WAW'(1);
                  pix_d      = '0;
                  res_rd_d   = 1'b1;
                  res_addr_d = AW'({word_q + WAW'(1), 4'd0});
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pix_q       <= '0;
         word_q      <= '0;
         shift_q     <= '0;
         fg_q        <= '0;
         thr_q       <= '0;
         rd_q        <= 1'b0;
         res_rd_q    <= 1'b0;
         res_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         word_q      <= word_d;
         shift_q     <= shift_d;
         fg_q        <= fg_d;
         thr_q       <= thr_d;
         rd_q        <= rd_d;
         res_rd_q    <= res_rd_d;
         res_addr_q  <= res_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign res_rd    = res_rd_q;
   assign res_addr  = res_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign fg_count  = fg_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
